// File: rtl/ahb_lite_slave_mem.sv
// ahb_lite_slave_mem: AHB-Lite memory responder.
// Holds a 2^SLAVE_ADDRWIDTH x DATAWIDTH word memory. It decodes the pipelined
// address/data phases and applies HSIZE byte-lane strobes on writes. It adds
// WAIT_STATES wait cycles to every OKAY data phase. Out-of-range, oversize
// and misaligned transfers get the two-cycle ERROR response.
// Ports:
//   HCLK, HRESET (sync, active-high)
//   HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA, HREADY  - bus inputs
//   HRDATA, HREADYOUT, HRESP - registered slave responses
module ahb_lite_slave_mem #(
  parameter int unsigned DATAWIDTH       = 32,
  parameter int unsigned ADDRWIDTH       = 32,
  parameter int unsigned SLAVE_ADDRWIDTH = 10,
  parameter int unsigned WAIT_STATES     = 0
) (
  input  logic                 HCLK,
  input  logic                 HRESET,
  input  logic                 HSEL,
  input  logic [ADDRWIDTH-1:0] HADDR,
  input  logic [1:0]           HTRANS,
  input  logic                 HWRITE,
  input  logic [2:0]           HSIZE,
  input  logic [2:0]           HBURST,
  input  logic [DATAWIDTH-1:0] HWDATA,
  input  logic                 HREADY,
  output logic [DATAWIDTH-1:0] HRDATA,
  output logic                 HREADYOUT,
  output logic                 HRESP
);

  localparam int unsigned DEPTH  = 1 << SLAVE_ADDRWIDTH;
  localparam int unsigned IDXW   = SLAVE_ADDRWIDTH;
  localparam int unsigned LOCW   = SLAVE_ADDRWIDTH + 2;
  localparam int unsigned CNTW   = 4;
  localparam int unsigned NBYTES = DATAWIDTH / 8;

  localparam logic [2:0] SIZE_BYTE  = 3'd0;
  localparam logic [2:0] SIZE_HALF  = 3'd1;
  localparam logic [2:0] SIZE_WORD  = 3'd2;
  localparam logic       RESP_OKAY  = 1'b0;
  localparam logic       RESP_ERROR = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DATA,
    ST_ERR1,
    ST_ERR2
  } state_t;

  state_t               state_q, state_d;
  logic [CNTW-1:0]      cnt_q, cnt_d;
  logic [LOCW-1:0]      addr_q;
  logic                 write_q;
  logic [2:0]           size_q;
  logic [DATAWIDTH-1:0] mem [DEPTH];

  logic                 start_c;
  logic                 req_err_c;
  logic                 ready_d, resp_d;
  logic                 wr_en;
  logic [IDXW-1:0]      wr_idx;
  logic [NBYTES-1:0]    be;
  logic [DATAWIDTH-1:0] wmask;
  logic [IDXW-1:0]      rd_idx;
  logic                 rd_write;
  logic [DATAWIDTH-1:0] rd_word, rdata_d;

  // HTRANS[0] only separates NONSEQ/SEQ and IDLE/BUSY; HBURST is informational.
  logic unused_inputs;
  assign unused_inputs = ^{HTRANS[0], HBURST};

  // A new address phase is accepted only when no data phase is still stalling.
  always_comb begin
    start_c = 1'b0;
    if (state_q == ST_IDLE || state_q == ST_DATA || state_q == ST_ERR2)
      start_c = HSEL & HREADY & HTRANS[1];
  end

  // Illegal transfer decode: out of range, oversize, misaligned.
  always_comb begin
    req_err_c = 1'b0;
    if (HADDR[ADDRWIDTH-1:LOCW] != '0)                  req_err_c = 1'b1;
    if (HSIZE > SIZE_WORD)                              req_err_c = 1'b1;
    if (HSIZE == SIZE_HALF && HADDR[0])                 req_err_c = 1'b1;
    if (HSIZE == SIZE_WORD && HADDR[1:0] != 2'b00)      req_err_c = 1'b1;
  end

  // Next state and next registered outputs.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ready_d = 1'b1;
    resp_d  = RESP_OKAY;
    case (state_q)
      ST_IDLE, ST_DATA, ST_ERR2: begin
        state_d = ST_IDLE;
        if (start_c) begin
          cnt_d = '0;
          if (req_err_c)              state_d = ST_ERR1;
          else if (WAIT_STATES != 0)  state_d = ST_WAIT;
          else                        state_d = ST_DATA;
        end
      end
      ST_WAIT: begin
        if (cnt_q == CNTW'(WAIT_STATES - 1)) state_d = ST_DATA;
        else                                 cnt_d   = cnt_q + CNTW'(1);
      end
      ST_ERR1: state_d = ST_ERR2;
      default: state_d = ST_IDLE;
    endcase
    case (state_d)
      ST_WAIT: ready_d = 1'b0;
      ST_ERR1: begin ready_d = 1'b0; resp_d = RESP_ERROR; end
      ST_ERR2: resp_d = RESP_ERROR;
      default: ;
    endcase
  end

  // Write lanes, little-endian.
  always_comb begin
    be = '0;
    case (size_q)
      SIZE_BYTE: be = 4'b0001 << addr_q[1:0];
      SIZE_HALF: be = addr_q[1] ? 4'b1100 : 4'b0011;
      SIZE_WORD: be = 4'b1111;
      default:   be = '0;
    endcase
    wmask  = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    wr_en  = (state_q == ST_DATA) && write_q;
    wr_idx = addr_q[LOCW-1:2];
  end

  // HRDATA is registered, so a write committing on the same edge as the read
  // data is loaded must be merged in to present the post-write word.
  always_comb begin
    rd_idx   = start_c ? HADDR[LOCW-1:2] : addr_q[LOCW-1:2];
    rd_write = start_c ? HWRITE : write_q;
    rd_word  = mem[rd_idx];
    if (wr_en && (wr_idx == rd_idx))
      rd_word = (rd_word & ~wmask) | (HWDATA & wmask);
    rdata_d  = (state_d == ST_DATA && !rd_write) ? rd_word : '0;
  end

  // Control, address-phase capture and output registers.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      write_q   <= 1'b0;
      size_q    <= SIZE_BYTE;
      HREADYOUT <= 1'b1;
      HRESP     <= RESP_OKAY;
      HRDATA    <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      HREADYOUT <= ready_d;
      HRESP     <= resp_d;
      HRDATA    <= rdata_d;
      if (start_c) begin
        addr_q  <= HADDR[LOCW-1:0];
        write_q <= HWRITE;
        size_q  <= HSIZE;
      end
    end
  end

  // Memory array; reset clears every word.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[IDXW'(i)] <= '0;
    end else if (wr_en) begin
      mem[wr_idx] <= (mem[wr_idx] & ~wmask) | (HWDATA & wmask);
    end
  end

endmodule
